// File: rtl/divider_32by16_seq_pkg.sv
// -----------------------------------------------------------------------------
// divider_32by16_seq_pkg
// Shared calculator definitions used by the sequential divider:
//   - div_state_t        : 2-bit FSM state encoding (IDLE/RUN/DONE)
//   - CALC_NUM_WIDTH     : operand width of the calculator (divisor/remainder)
//   - CALC_ANSWER_WIDTH  : answer path width (dividend/quotient)
//   - cnt_width()        : width of an iteration counter for a given count
// -----------------------------------------------------------------------------
package divider_32by16_seq_pkg;

  localparam int CALC_NUM_WIDTH    = 16;
  localparam int CALC_ANSWER_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/divider_32by16_seq_if.sv
// -----------------------------------------------------------------------------
// divider_32by16_seq_if
// Start/busy/done handshake and result bus between the calculator control
// logic (master) and the sequential divider (slave).
//   IN_start        master->slave  request a division (sampled in IDLE only)
//   IN_dividend     master->slave  unsigned dividend, N_WIDTH bits
//   IN_divisor      master->slave  unsigned divisor, D_WIDTH bits
//   OUT_busy        slave->master  high while iterating
//   OUT_done        slave->master  one-cycle pulse, results valid
//   OUT_quotient    slave->master  registered quotient, N_WIDTH bits
//   OUT_remainder   slave->master  registered remainder, D_WIDTH bits
//   OUT_div_by_zero slave->master  last operation had a zero divisor
// -----------------------------------------------------------------------------
interface divider_32by16_seq_if
  import divider_32by16_seq_pkg::*;
#(
  parameter int N_WIDTH = CALC_ANSWER_WIDTH,
  parameter int D_WIDTH = CALC_NUM_WIDTH
) ();

  logic               IN_start;
  logic [N_WIDTH-1:0] IN_dividend;
  logic [D_WIDTH-1:0] IN_divisor;
  logic               OUT_busy;
  logic               OUT_done;
  logic [N_WIDTH-1:0] OUT_quotient;
  logic [D_WIDTH-1:0] OUT_remainder;
  logic               OUT_div_by_zero;

  modport master (
    output IN_start, IN_dividend, IN_divisor,
    input  OUT_busy, OUT_done, OUT_quotient, OUT_remainder, OUT_div_by_zero
  );

  modport slave (
    input  IN_start, IN_dividend, IN_divisor,
    output OUT_busy, OUT_done, OUT_quotient, OUT_remainder, OUT_div_by_zero
  );

endinterface

// File: rtl/divider_32by16_seq_step.sv
// -----------------------------------------------------------------------------
// divider_32by16_seq_step
// One combinational restoring-division iteration.
//   rem_in       partial remainder before the step (D_WIDTH+1 bits)
//   dividend_msb next dividend bit brought down into the remainder
//   divisor      divisor
//   rem_out      partial remainder after the step
//   q_bit        quotient bit produced by this step
// -----------------------------------------------------------------------------
module divider_32by16_seq_step #(
  parameter int D_WIDTH = 16
) (
  input  logic [D_WIDTH:0]   rem_in,
  input  logic               dividend_msb,
  input  logic [D_WIDTH-1:0] divisor,
  output logic [D_WIDTH:0]   rem_out,
  output logic               q_bit
);

  // One spare bit on top of the shifted remainder holds the borrow, so the
  // subtraction sign is simply the MSB of the difference.
  logic [D_WIDTH+1:0] shifted_w;
  logic [D_WIDTH+1:0] trial_w;

  assign shifted_w = {rem_in, dividend_msb};
  assign trial_w   = shifted_w - {2'b00, divisor};

  // Non-negative trial: keep the difference, quotient bit is 1.
  // Negative trial: restore (keep the shifted value), quotient bit is 0.
  assign q_bit   = ~trial_w[D_WIDTH+1];
  assign rem_out = q_bit ? trial_w[D_WIDTH:0] : shifted_w[D_WIDTH:0];

endmodule

// File: rtl/divider_32by16_seq.sv
// -----------------------------------------------------------------------------
// divider_32by16_seq
// Sequential restoring divider: N_WIDTH-bit dividend / D_WIDTH-bit divisor,
// one quotient bit per clock, start/busy/done handshake.
//   IN_clk    system clock, rising edge
//   IN_reset  asynchronous active-high reset; aborts a running division
//   bus       divider_32by16_seq_if.slave (operands in, results/status out)
// Timing: start accepted on edge E0, N_WIDTH iterations follow, then a
// single DONE cycle with OUT_done high. A zero divisor skips the iterations
// and reaches DONE straight from IDLE.
// -----------------------------------------------------------------------------
module divider_32by16_seq
  import divider_32by16_seq_pkg::*;
#(
  parameter int N_WIDTH = CALC_ANSWER_WIDTH,
  parameter int D_WIDTH = CALC_NUM_WIDTH
) (
  input  logic                  IN_clk,
  input  logic                  IN_reset,
  divider_32by16_seq_if.slave   bus
);

  localparam int                CNT_W     = cnt_width(N_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(N_WIDTH - 1);

  div_state_t          state_reg;
  div_state_t          state_next;

  logic [N_WIDTH-1:0]  dividend_reg;    // dividend bits out at the top, quotient bits in at the bottom
  logic [D_WIDTH-1:0]  divisor_reg;
  logic [D_WIDTH:0]    partial_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [N_WIDTH-1:0]  quotient_reg;
  logic [D_WIDTH-1:0]  remainder_reg;
  logic                dbz_reg;

  logic                load_op;
  logic                load_zero;
  logic                iterate;
  logic                finish;

  logic [D_WIDTH:0]    partial_next;
  logic                q_bit;
  logic [N_WIDTH-1:0]  dividend_next;

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  divider_32by16_seq_step #(
    .D_WIDTH (D_WIDTH)
  ) u_step (
    .rem_in       (partial_reg),
    .dividend_msb (dividend_reg[N_WIDTH-1]),
    .divisor      (divisor_reg),
    .rem_out      (partial_next),
    .q_bit        (q_bit)
  );

  // Shift the dividend register left, inserting the new quotient bit.
  assign dividend_next[0] = q_bit;
  generate
    for (genvar gi = 1; gi < N_WIDTH; gi++) begin : g_shift
      assign dividend_next[gi] = dividend_reg[gi-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge IN_clk or posedge IN_reset) begin
    if (IN_reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load_op    = 1'b0;
    load_zero  = 1'b0;
    iterate    = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.IN_start) begin
          if (bus.IN_divisor != '0) begin
            load_op    = 1'b1;
            state_next = ST_RUN;
          end else begin
            load_zero  = 1'b1;
            state_next = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        iterate = 1'b1;
        if (count_reg == LAST_ITER) begin
          finish     = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand, iteration and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge IN_clk or posedge IN_reset) begin
    if (IN_reset) begin
      dividend_reg  <= '0;
      divisor_reg   <= '0;
      partial_reg   <= '0;
      count_reg     <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      if (load_op) begin
        dividend_reg <= bus.IN_dividend;
        divisor_reg  <= bus.IN_divisor;
        partial_reg  <= '0;
        count_reg    <= '0;
        dbz_reg      <= 1'b0;
      end
      // Zero divisor: saturated quotient, low dividend bits as remainder.
      if (load_zero) begin
        quotient_reg  <= '1;
        remainder_reg <= bus.IN_dividend[D_WIDTH-1:0];
        dbz_reg       <= 1'b1;
      end
      if (iterate) begin
        dividend_reg <= dividend_next;
        partial_reg  <= partial_next;
        count_reg    <= count_reg + 1'b1;
      end
      // Results are published only on the final iteration so the outputs
      // stay stable for the whole run.
      if (finish) begin
        quotient_reg  <= dividend_next;
        remainder_reg <= partial_next[D_WIDTH-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.OUT_busy        = (state_reg == ST_RUN);
  assign bus.OUT_done        = (state_reg == ST_DONE);
  assign bus.OUT_quotient    = quotient_reg;
  assign bus.OUT_remainder   = remainder_reg;
  assign bus.OUT_div_by_zero = dbz_reg;

endmodule

// File: tb/tb_divider_32by16_seq.sv
// -----------------------------------------------------------------------------
// tb_divider_32by16_seq
// Directed bench for divider_32by16_seq: reset values, basic and boundary
// divisions, divide-by-zero, start ignored while busy, reset mid-run and
// back-to-back operations with start held high.
// -----------------------------------------------------------------------------
module tb_divider_32by16_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  divider_32by16_seq_if #(.N_WIDTH(32), .D_WIDTH(16)) bus ();

  divider_32by16_seq #(.N_WIDTH(32), .D_WIDTH(16)) dut (
    .IN_clk   (clk),
    .IN_reset (rst),
    .bus      (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One division transaction. Returns with the bench one cycle after done.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [15:0] b,
                         input logic [31:0] exp_q, input logic [15:0] exp_r,
                         input logic exp_dbz, input int exp_lat, input bit poke);
    int lat;
    int busy_cyc;
    logic [31:0] held_q;
    held_q          = bus.OUT_quotient;
    bus.IN_start    = 1'b1;
    bus.IN_dividend = a;
    bus.IN_divisor  = b;
    @(posedge clk); #1;
    // Operands scrambled after acceptance; they must not affect the result.
    bus.IN_start    = 1'b0;
    bus.IN_dividend = 32'hDEAD_BEEF;
    bus.IN_divisor  = 16'h0003;
    lat      = 1;
    busy_cyc = 0;
    while (!bus.OUT_done && lat < 100) begin
      if (bus.OUT_busy) busy_cyc++;
      if (lat == 16) chk({tag, " q_hold_run"}, bus.OUT_quotient, held_q);
      if (poke && (lat == 5 || lat == 20)) begin
        bus.IN_start    = 1'b1;
        bus.IN_dividend = 32'h0000_FFFF;
        bus.IN_divisor  = 16'h0002;
      end else begin
        bus.IN_start    = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.IN_start = 1'b0;
    chk({tag, " done"},      bus.OUT_done, 1'b1);
    chk({tag, " latency"},   lat, exp_lat);
    chk({tag, " quotient"},  bus.OUT_quotient, exp_q);
    chk({tag, " remainder"}, bus.OUT_remainder, exp_r);
    chk({tag, " dbz"},       bus.OUT_div_by_zero, exp_dbz);
    chk({tag, " busy_cyc"},  busy_cyc, exp_dbz ? 0 : 32);
    chk({tag, " busy_at_done"}, bus.OUT_busy, 1'b0);
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, bus.OUT_done, 1'b0);
    chk({tag, " q_hold_after"}, bus.OUT_quotient, exp_q);
    $display("txn %s: 0x%08h / 0x%04h -> q=0x%08h r=0x%04h dbz=%0b lat=%0d",
             tag, a, b, bus.OUT_quotient, bus.OUT_remainder, bus.OUT_div_by_zero, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cyc;
    int done_rise;
    logic prev_done;

    bus.IN_start    = 1'b0;
    bus.IN_dividend = '0;
    bus.IN_divisor  = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", bus.OUT_busy, 1'b0);
    chk("rst done", bus.OUT_done, 1'b0);
    chk("rst quotient", bus.OUT_quotient, 32'h0);
    chk("rst remainder", bus.OUT_remainder, 16'h0);
    chk("rst dbz", bus.OUT_div_by_zero, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed divisions
    run_div("basic",      32'd100,        16'd7,      32'd14,        16'd2,      1'b0, 33, 1'b0);
    run_div("mul_inv",    32'h0C37_4FA4,  16'h1234,   32'h0000_ABCD, 16'h0000,   1'b0, 33, 1'b0);
    run_div("max_by_1",   32'hFFFF_FFFF,  16'h0001,   32'hFFFF_FFFF, 16'h0000,   1'b0, 33, 1'b0);
    run_div("max_by_max", 32'hFFFF_FFFF,  16'hFFFF,   32'h0001_0001, 16'h0000,   1'b0, 33, 1'b0);
    run_div("small",      32'd5,          16'd9,      32'd0,         16'd5,      1'b0, 33, 1'b0);
    run_div("div0",       32'h1234_5678,  16'h0000,   32'hFFFF_FFFF, 16'h5678,   1'b1, 1,  1'b0);
    run_div("clear_dbz",  32'h1234_5678,  16'h0100,   32'h0012_3456, 16'h0078,   1'b0, 33, 1'b0);
    run_div("ign_start",  32'd1000,       16'd3,      32'd333,       16'd1,      1'b0, 33, 1'b1);

    // Reset in cycle 10 of RUN
    bus.IN_start    = 1'b1;
    bus.IN_dividend = 32'd1000;
    bus.IN_divisor  = 16'd7;
    @(posedge clk); #1;
    bus.IN_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("pre_rst busy", bus.OUT_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst busy", bus.OUT_busy, 1'b0);
    chk("mid_rst done", bus.OUT_done, 1'b0);
    chk("mid_rst quotient", bus.OUT_quotient, 32'h0);
    chk("mid_rst remainder", bus.OUT_remainder, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    done_cyc = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.OUT_done) done_cyc++;
    end
    chk("mid_rst no_done", done_cyc, 0);
    run_div("after_rst", 32'd100, 16'd7, 32'd14, 16'd2, 1'b0, 33, 1'b0);

    // Start held high: back-to-back operations, single-cycle done each
    bus.IN_start    = 1'b1;
    bus.IN_dividend = 32'd200;
    bus.IN_divisor  = 16'd10;
    done_cyc  = 0;
    done_rise = 0;
    prev_done = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (bus.OUT_done) begin
        done_cyc++;
        if (!prev_done) done_rise++;
        chk("b2b quotient", bus.OUT_quotient, 32'd20);
      end
      prev_done = bus.OUT_done;
    end
    bus.IN_start = 1'b0;
    chk("b2b done_cycles", done_cyc, 2);
    chk("b2b done_pulses", done_rise, 2);
    repeat (40) @(posedge clk);
    #1;
    chk("b2b idle busy", bus.OUT_busy, 1'b0);
    chk("b2b remainder", bus.OUT_remainder, 16'd0);
    $display("txn b2b: 200 / 10 start held, done pulses=%0d", done_rise);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
